wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage: consumes the MEM/WB pipeline register outputs and commits
//  results to a 32 x 8-bit register file plus a 14-bit return-address stack (RAS).
//  Provides two combinational read ports with write-through bypass to decode, and
//  the RAS top-of-stack to fetch. Sits between mem_wb and the ID-stage operand mux.
// PARAMETERS
//  NUM_REGS     32     register count; address width = 5; power of two
//  RAS_DEPTH    8      return-address stack entries; power of two, >= 2
//  OPC_CALL     6'h30  instr[31:26] value that pushes ret_addr_in
//  OPC_RET      6'h31  instr[31:26] value that pops the RAS
// PORTS
//  clock            in   1   system clock, all state on posedge
//  nreset           in   1   asynchronous active-low reset
//  data_top_in      in   8   write data for register rd (from mem_wb data_top_out)
//  data_bot_in      in   8   write data for register rd+1 (from mem_wb data_bot_out)
//  instruction_in   in   32  WB instruction; [31:26] opcode, [20:16] rd
//  reg_file_wen_in  in   2   [1] write top to rd, [0] write bot to rd+1
//  ret_addr_in      in   14  return address pushed on OPC_CALL
//  rd_addr_a        in   5   read port A address (decode)
//  rd_addr_b        in   5   read port B address (decode)
//  rd_data_a        out  8   read port A data, combinational
//  rd_data_b        out  8   read port B data, combinational
//  ras_top          out  14  current top-of-stack entry; 0 when empty
//  ras_empty        out  1   stack holds 0 entries
//  ras_full         out  1   stack holds RAS_DEPTH entries
//  ras_overflow     out  1   sticky: push attempted while full
//  ras_underflow    out  1   sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (nreset=0, async, any time incl. mid-operation): all registers = 0, RAS
//   entries = 0, count = 0; ras_top=0, ras_empty=1, ras_full=0, flags=0.
//   Reset dominates any write/push/pop on the same edge.
//  Writes: on posedge, wen[1] -> reg[rd] <= data_top_in; wen[0] ->
//   reg[(rd+1) mod 32] <= data_bot_in (rd=31 wraps bot to reg 0). wen=2'b00 = bubble.
//  Register 0 is hard-wired zero: writes to it are discarded; reads return 0.
//  Read latency 0: rd_data_x = reg[rd_addr_x], except when the address matches an
//   enabled write this cycle (and is not reg 0), in which case the write data is
//   returned (bypass). Top and bot targets never collide (rd != rd+1 mod 32).
//  RAS is an up-counter stack, count range 0..RAS_DEPTH:
//   opcode==OPC_CALL & !full: entry[count] <= ret_addr_in, count+1.
//   opcode==OPC_CALL & full: push dropped, contents unchanged, ras_overflow <= 1.
//   opcode==OPC_RET & !empty: count-1 (popped entry value is don't-care after pop).
//   opcode==OPC_RET & empty: no change, ras_underflow <= 1.
//   Push/pop are independent of reg_file_wen_in; CALL may also write registers.
//  ras_top = entry[count-1] when count>0 else 0; empty/full derived from count,
//   all registered-state outputs valid the cycle after the edge.
//  Sticky flags clear only on reset.
// TESTING
//  Reset, then read A=5/B=31 -> 0/0; ras_empty=1, ras_top=0, all flags 0.
//  rd=3, wen=2'b11, top=8'hA5, bot=8'h5A -> same cycle A=3 bypass gives A5; next
//   cycle reg3=A5, reg4=5A.
//  rd=31, wen=2'b11, top=8'h11, bot=8'h22 -> reg31=11; reg0 still reads 0 (wrap dropped).
//  8 CALLs with ret_addr 14'h100..14'h107 -> ras_full=1, ras_top=14'h107; 9th CALL
//   (14'h3FFF) -> ras_top stays 14'h107, ras_overflow=1.
//  9 RETs from full -> after 8th ras_empty=1, ras_top=0; 9th sets ras_underflow=1.
//  nreset low mid-burst (regs written, RAS count=3) -> immediately all outputs at reset values.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: commits MEM/WB results to a 32 x 8-bit register file and
// maintains the return-address stack, with write-through bypass on both read ports.
module wb_regfile #(
  parameter int         NUM_REGS  = 32,
  parameter int         RAS_DEPTH = 8,
  parameter logic [5:0] OPC_CALL  = 6'h30,
  parameter logic [5:0] OPC_RET   = 6'h31
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [7:0]  data_top_in,
  input  logic [7:0]  data_bot_in,
  input  logic [31:0] instruction_in,
  input  logic [1:0]  reg_file_wen_in,
  input  logic [13:0] ret_addr_in,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [7:0]  rd_data_a,
  output logic [7:0]  rd_data_b,
  output logic [13:0] ras_top,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int AW = 5;
  localparam int SW = $clog2(RAS_DEPTH);
  localparam logic [SW:0] DEPTH_CNT = (SW+1)'(RAS_DEPTH);

  logic [7:0]    regs    [NUM_REGS];
  logic [13:0]   ras_mem [RAS_DEPTH];
  logic [SW:0]   ras_count;
  logic [SW-1:0] top_idx;

  logic [5:0]    opcode;
  logic [AW-1:0] rd_top;
  logic [AW-1:0] rd_bot;
  logic          wr_top;
  logic          wr_bot;
  logic          is_call;
  logic          is_ret;
  logic          unused_instr_bits;

  assign opcode            = instruction_in[31:26];
  assign rd_top            = instruction_in[20:16];
  assign rd_bot            = rd_top + AW'(1);
  assign unused_instr_bits = ^{instruction_in[25:21], instruction_in[15:0]};

  // Writes aimed at register 0 are dropped here, so bypass and storage agree.
  assign wr_top  = reg_file_wen_in[1] && (rd_top != '0);
  assign wr_bot  = reg_file_wen_in[0] && (rd_bot != '0);
  assign is_call = (opcode == OPC_CALL);
  assign is_ret  = (opcode == OPC_RET);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_top) regs[rd_top] <= data_top_in;
      if (wr_bot) regs[rd_bot] <= data_bot_in;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0)                           rd_data_a = '0;
    else if (wr_top && (rd_addr_a == rd_top))      rd_data_a = data_top_in;
    else if (wr_bot && (rd_addr_a == rd_bot))      rd_data_a = data_bot_in;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0)                           rd_data_b = '0;
    else if (wr_top && (rd_addr_b == rd_top))      rd_data_b = data_top_in;
    else if (wr_bot && (rd_addr_b == rd_bot))      rd_data_b = data_bot_in;
  end

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == DEPTH_CNT);

  // A full stack has count[SW-1:0] == 0, so the wrapped decrement still lands on the last slot.
  assign top_idx = ras_count[SW-1:0] - SW'(1);
  assign ras_top = ras_empty ? '0 : ras_mem[top_idx];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (is_call) begin
      if (!ras_full) begin
        ras_mem[ras_count[SW-1:0]] <= ret_addr_in;
        ras_count                  <= ras_count + (SW+1)'(1);
      end else begin
        ras_overflow <= 1'b1;
      end
    end else if (is_ret) begin
      if (!ras_empty) ras_count     <= ras_count - (SW+1)'(1);
      else            ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued in a scoreboard as
// stimulus is driven and popped when the matching DUT output is sampled.
module tb_wb_regfile;

  localparam logic [5:0] OPC_CALL = 6'h30;
  localparam logic [5:0] OPC_RET  = 6'h31;
  localparam logic [5:0] OPC_NOP  = 6'h00;

  logic        clock = 1'b0;
  logic        nreset;
  logic [7:0]  data_top_in;
  logic [7:0]  data_bot_in;
  logic [31:0] instruction_in;
  logic [1:0]  reg_file_wen_in;
  logic [13:0] ret_addr_in;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic [13:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] model_ras[$];
  bit          model_ovf;
  bit          model_unf;
  int          checks = 0;
  int          errors = 0;

  wb_regfile dut (
    .clock           (clock),
    .nreset          (nreset),
    .data_top_in     (data_top_in),
    .data_bot_in     (data_bot_in),
    .instruction_in  (instruction_in),
    .reg_file_wen_in (reg_file_wen_in),
    .ret_addr_in     (ret_addr_in),
    .rd_addr_a       (rd_addr_a),
    .rd_addr_b       (rd_addr_b),
    .rd_data_a       (rd_data_a),
    .rd_data_b       (rd_data_b),
    .ras_top         (ras_top),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [5:0] opc, input logic [4:0] rd, input logic [1:0] wen,
                               input logic [7:0] top, input logic [7:0] bot, input logic [13:0] ret);
    instruction_in  = {opc, 5'b0, rd, 16'h0};
    reg_file_wen_in = wen;
    data_top_in     = top;
    data_bot_in     = bot;
    ret_addr_in     = ret;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_underrun observed=%0h expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
      end
    end
  endtask

  // Reference stack behaviour, advanced at each rising edge from the driven inputs.
  task automatic clockEdge();
    @(posedge clock);
    if (!nreset) begin
      model_ras.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else if (instruction_in[31:26] == OPC_CALL) begin
      if (model_ras.size() < 8) model_ras.push_back(ret_addr_in);
      else                      model_ovf = 1'b1;
    end else if (instruction_in[31:26] == OPC_RET) begin
      if (model_ras.size() > 0) void'(model_ras.pop_back());
      else                      model_unf = 1'b1;
    end
    #1;
  endtask

  task automatic checkRas(input string tag);
    expectVal({tag, "_top"},   (model_ras.size() > 0) ? 32'(model_ras[$]) : 32'h0);
    expectVal({tag, "_empty"}, 32'(model_ras.size() == 0));
    expectVal({tag, "_full"},  32'(model_ras.size() == 8));
    expectVal({tag, "_ovf"},   32'(model_ovf));
    expectVal({tag, "_unf"},   32'(model_unf));
    checkOutput(32'(ras_top));
    checkOutput(32'(ras_empty));
    checkOutput(32'(ras_full));
    checkOutput(32'(ras_overflow));
    checkOutput(32'(ras_underflow));
  endtask

  task automatic checkReads(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
    expectVal({tag, "_a"}, 32'(exp_a));
    expectVal({tag, "_b"}, 32'(exp_b));
    checkOutput(32'(rd_data_a));
    checkOutput(32'(rd_data_b));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nreset = 1'b0;
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd31;
    repeat (2) clockEdge();
    nreset = 1'b1;
    #1;
    checkReads("reset_rd", 8'h00, 8'h00);
    checkRas("reset");

    // Same-cycle bypass, then the committed values.
    applyStimulus(OPC_NOP, 5'd3, 2'b11, 8'hA5, 8'h5A, 14'h0);
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd4;
    #1;
    checkReads("bypass_r3", 8'hA5, 8'h5A);
    clockEdge();
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    #1;
    checkReads("commit_r3", 8'hA5, 8'h5A);

    applyStimulus(OPC_NOP, 5'd31, 2'b11, 8'h11, 8'h22, 14'h0);
    rd_addr_a = 5'd31;
    rd_addr_b = 5'd0;
    #1;
    checkReads("bypass_wrap", 8'h11, 8'h00);
    clockEdge();
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    #1;
    checkReads("commit_wrap", 8'h11, 8'h00);

    applyStimulus(OPC_NOP, 5'd10, 2'b10, 8'h3C, 8'h77, 14'h0);
    clockEdge();
    applyStimulus(OPC_NOP, 5'd20, 2'b01, 8'h99, 8'h66, 14'h0);
    clockEdge();
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    rd_addr_a = 5'd10;
    rd_addr_b = 5'd11;
    #1;
    checkReads("top_only", 8'h3C, 8'h00);
    rd_addr_a = 5'd20;
    rd_addr_b = 5'd21;
    #1;
    checkReads("bot_only", 8'h00, 8'h66);

    // Fill the stack; the first CALL also writes a register.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OPC_CALL, 5'd12, (i == 0) ? 2'b10 : 2'b00, 8'hC3, 8'h00, 14'h100 + 14'(i));
      clockEdge();
      checkRas($sformatf("call%0d", i));
    end
    applyStimulus(OPC_CALL, 5'd0, 2'b00, 8'h00, 8'h00, 14'h3FFF);
    clockEdge();
    checkRas("call_overflow");
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    rd_addr_a = 5'd12;
    rd_addr_b = 5'd3;
    #1;
    checkReads("call_write", 8'hC3, 8'hA5);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(OPC_RET, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
      clockEdge();
      checkRas($sformatf("ret%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(OPC_CALL, 5'd0, 2'b00, 8'h00, 8'h00, 14'h200 + 14'(i));
      clockEdge();
    end
    checkRas("preburst");

    // Asynchronous reset in the middle of a CALL burst.
    applyStimulus(OPC_CALL, 5'd0, 2'b00, 8'h00, 8'h00, 14'h2AA);
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd31;
    #2;
    nreset = 1'b0;
    model_ras.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    checkReads("async_rst_rd", 8'h00, 8'h00);
    checkRas("async_rst");
    clockEdge();
    checkRas("rst_hold");
    nreset = 1'b1;
    applyStimulus(OPC_NOP, 5'd0, 2'b00, 8'h00, 8'h00, 14'h0);
    rd_addr_a = 5'd12;
    rd_addr_b = 5'd21;
    #1;
    checkReads("post_rst_rd", 8'h00, 8'h00);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
